// File: rtl/wb_stage_if.sv
// Memory-stage to write-back-stage bundle: valid/allowin handshake plus the
// latched instruction fields. The memory stage is the master, WB the slave.
interface wb_stage_if;
  logic        mem_valid_in;
  logic        wb_allowin_out;
  logic [31:0] mem_pc_in;
  logic [31:0] mem_wbdata_in;
  logic [2:0]  mem_sel_wbdata_in;
  logic [4:0]  mem_lubhw_con_in;
  logic [1:0]  mem_adrl_in;
  logic [2:0]  mem_write_type_in;
  logic [3:0]  mem_llr_we_in;
  logic [4:0]  mem_wnum_in;

  modport master (
    output mem_valid_in, mem_pc_in, mem_wbdata_in, mem_sel_wbdata_in,
    output mem_lubhw_con_in, mem_adrl_in, mem_write_type_in, mem_llr_we_in,
    output mem_wnum_in,
    input  wb_allowin_out
  );

  modport slave (
    input  mem_valid_in, mem_pc_in, mem_wbdata_in, mem_sel_wbdata_in,
    input  mem_lubhw_con_in, mem_adrl_in, mem_write_type_in, mem_llr_we_in,
    input  mem_wnum_in,
    output wb_allowin_out
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: load extraction / LWL-LWR merge, register-file write port,
// forwarding view and retire counter. Optional trace ports: WB_DEBUG_TRACE_EN.
module wb_stage #(
  parameter int DATA_W       = 32,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  wb_stage_if.slave               mem_if,
  input  logic [DATA_W-1:0]       data_sram_rdata,
  output logic [3:0]              rf_we,
  output logic [4:0]              rf_wnum,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic                    wb_fwd_valid,
  output logic [4:0]              wb_fwd_wnum,
  output logic [DATA_W-1:0]       wb_fwd_data,
  output logic [RETIRE_CNT_W-1:0] retire_cnt
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
`endif
);

  function automatic logic [31:0] load_byte(input logic [31:0] w, input logic [1:0] a,
                                            input logic sgn);
    logic [7:0] b;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    load_byte = {{24{sgn & b[7]}}, b};
  endfunction

  // adrl[0] is ignored: misaligned halfword loads never reach this stage.
  function automatic logic [31:0] load_half(input logic [31:0] w, input logic a1,
                                            input logic sgn);
    logic [15:0] h;
    if (a1) begin
      h = w[31:16];
    end else begin
      h = w[15:0];
    end
    load_half = {{16{sgn & h[15]}}, h};
  endfunction

  function automatic logic [31:0] merge_lwl(input logic [31:0] w, input logic [1:0] a);
    logic [1:0] nb;
    nb        = 2'd3 - a;
    merge_lwl = w << {nb, 3'b000};
  endfunction

  function automatic logic [31:0] merge_lwr(input logic [31:0] w, input logic [1:0] a);
    merge_lwr = w >> {a, 3'b000};
  endfunction

  logic                    ready_s;
  logic                    allowin_s;
  logic                    valid_q,   valid_d;
  logic [DATA_W-1:0]       wbdata_q,  wbdata_d;
  logic                    sel_q,     sel_d;
  logic [4:0]              lubhw_q,   lubhw_d;
  logic [1:0]              adrl_q,    adrl_d;
  logic [2:0]              wtype_q,   wtype_d;
  logic [3:0]              llr_we_q,  llr_we_d;
  logic [4:0]              wnum_q,    wnum_d;
  logic [RETIRE_CNT_W-1:0] retire_q,  retire_d;
  logic [DATA_W-1:0]       data_s;
  logic [3:0]              we_raw_s;

  assign ready_s               = 1'b1;
  assign allowin_s             = !valid_q || ready_s;
  assign mem_if.wb_allowin_out = allowin_s;

  // Next-state: valid follows the handshake, fields load only with a valid instruction.
  always_comb begin
    valid_d  = valid_q;
    wbdata_d = wbdata_q;
    sel_d    = sel_q;
    lubhw_d  = lubhw_q;
    adrl_d   = adrl_q;
    wtype_d  = wtype_q;
    llr_we_d = llr_we_q;
    wnum_d   = wnum_q;
    if (allowin_s) begin
      valid_d = mem_if.mem_valid_in;
    end else begin
      valid_d = valid_q;
    end
    if (allowin_s && mem_if.mem_valid_in) begin
      wbdata_d = mem_if.mem_wbdata_in;
      sel_d    = mem_if.mem_sel_wbdata_in[2];
      lubhw_d  = mem_if.mem_lubhw_con_in;
      adrl_d   = mem_if.mem_adrl_in;
      wtype_d  = mem_if.mem_write_type_in;
      llr_we_d = mem_if.mem_llr_we_in;
      wnum_d   = mem_if.mem_wnum_in;
    end else begin
      wbdata_d = wbdata_q;
    end
    if (valid_q) begin
      retire_d = retire_q + {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_d = retire_q;
    end
  end

  // Stage registers and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      wbdata_q <= {DATA_W{1'b0}};
      sel_q    <= 1'b0;
      lubhw_q  <= 5'd0;
      adrl_q   <= 2'd0;
      wtype_q  <= 3'd0;
      llr_we_q <= 4'd0;
      wnum_q   <= 5'd0;
      retire_q <= {RETIRE_CNT_W{1'b0}};
    end else begin
      valid_q  <= valid_d;
      wbdata_q <= wbdata_d;
      sel_q    <= sel_d;
      lubhw_q  <= lubhw_d;
      adrl_q   <= adrl_d;
      wtype_q  <= wtype_d;
      llr_we_q <= llr_we_d;
      wnum_q   <= wnum_d;
      retire_q <= retire_d;
    end
  end

  // Write-data selection; the SRAM data belongs to the instruction in WB right now.
  always_comb begin
    data_s = wbdata_q;
    if (sel_q) begin
      data_s = wbdata_q;
    end else if (lubhw_q[0]) begin
      data_s = data_sram_rdata;
    end else if (lubhw_q[1] || lubhw_q[2]) begin
      data_s = load_byte(data_sram_rdata, adrl_q, lubhw_q[1]);
    end else if (lubhw_q[3] || lubhw_q[4]) begin
      data_s = load_half(data_sram_rdata, adrl_q[1], lubhw_q[3]);
    end else if (wtype_q == 3'b010) begin
      data_s = merge_lwl(data_sram_rdata, adrl_q);
    end else if (wtype_q == 3'b011) begin
      data_s = merge_lwr(data_sram_rdata, adrl_q);
    end else begin
      data_s = wbdata_q;
    end
  end

  // Byte enables before gating.
  always_comb begin
    we_raw_s = 4'b0000;
    case (wtype_q)
      3'b001:  we_raw_s = 4'b1111;
      3'b010:  we_raw_s = llr_we_q;
      3'b011:  we_raw_s = llr_we_q;
      default: we_raw_s = 4'b0000;
    endcase
  end

  // Register-file and forwarding outputs, all zero while the stage is empty.
  always_comb begin
    rf_we        = 4'b0000;
    rf_wnum      = 5'd0;
    rf_wdata     = {DATA_W{1'b0}};
    wb_fwd_valid = 1'b0;
    wb_fwd_wnum  = 5'd0;
    wb_fwd_data  = {DATA_W{1'b0}};
    if (valid_q) begin
      if (wnum_q != 5'd0) begin
        rf_we = we_raw_s;
      end else begin
        rf_we = 4'b0000;
      end
      rf_wnum      = wnum_q;
      rf_wdata     = data_s;
      wb_fwd_valid = (rf_we != 4'b0000);
      wb_fwd_wnum  = wnum_q;
      wb_fwd_data  = data_s;
    end else begin
      rf_we = 4'b0000;
    end
  end

  assign retire_cnt = retire_q;

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] pc_q;

  // PC is only needed for the trace view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= 32'd0;
    end else if (allowin_s && mem_if.mem_valid_in) begin
      pc_q <= mem_if.mem_pc_in;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign debug_wb_pc       = valid_q ? pc_q : 32'd0;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_wnum;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural model of
// the write-back rules.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] rd;
  logic [3:0]  rf_we;
  logic [4:0]  rf_wnum;
  logic [31:0] rf_wdata;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_wnum;
  logic [31:0] wb_fwd_data;
  logic [31:0] retire_cnt;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  wb_stage_if mif ();

  wb_stage #(.DATA_W(32), .RETIRE_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_if(mif), .data_sram_rdata(rd),
    .rf_we(rf_we), .rf_wnum(rf_wnum), .rf_wdata(rf_wdata),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_wnum(wb_fwd_wnum), .wb_fwd_data(wb_fwd_data),
    .retire_cnt(retire_cnt)
`ifdef WB_DEBUG_TRACE_EN
    , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );

  // Model: the instruction currently in WB and the number retired so far.
  bit          m_valid;
  logic [31:0] m_pc, m_wbdata, m_cnt;
  logic        m_sel2;
  logic [4:0]  m_lubhw, m_wnum;
  logic [1:0]  m_adrl;
  logic [2:0]  m_wtype;
  logic [3:0]  m_llr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_cnt = 32'd0; m_pc = 32'd0; m_wbdata = 32'd0; m_sel2 = 1'b0;
      m_lubhw = 5'd0; m_wnum = 5'd0; m_adrl = 2'd0; m_wtype = 3'd0; m_llr = 4'd0;
    end else begin
      if (m_valid) m_cnt = m_cnt + 32'd1;
      m_valid = mif.mem_valid_in;
      if (mif.mem_valid_in) begin
        m_pc = mif.mem_pc_in; m_wbdata = mif.mem_wbdata_in;
        m_sel2 = mif.mem_sel_wbdata_in[2]; m_lubhw = mif.mem_lubhw_con_in;
        m_adrl = mif.mem_adrl_in; m_wtype = mif.mem_write_type_in;
        m_llr = mif.mem_llr_we_in; m_wnum = mif.mem_wnum_in;
      end
    end
  end

  function automatic logic [31:0] exp_data();
    logic [31:0] v;
    if (m_sel2) return m_wbdata;
    if (m_lubhw[0]) return rd;
    if (m_lubhw[1] || m_lubhw[2]) begin
      v = (rd >> (8 * m_adrl)) & 32'h0000_00FF;
      if (m_lubhw[1] && v >= 32'd128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (m_lubhw[3] || m_lubhw[4]) begin
      v = (rd >> (16 * m_adrl[1])) & 32'h0000_FFFF;
      if (m_lubhw[3] && v >= 32'd32768) v = v + 32'hFFFF_0000;
      return v;
    end
    if (m_wtype == 3'd2) return rd << (8 * (3 - m_adrl));
    if (m_wtype == 3'd3) return rd >> (8 * m_adrl);
    return m_wbdata;
  endfunction

  function automatic logic [3:0] exp_we();
    if (!m_valid || m_wnum == 5'd0) return 4'd0;
    if (m_wtype == 3'd1) return 4'hF;
    if (m_wtype == 3'd2 || m_wtype == 3'd3) return m_llr;
    return 4'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every negedge: all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("allowin", {31'd0, mif.wb_allowin_out}, 32'd1);
      chk("rf_we", {28'd0, rf_we}, {28'd0, exp_we()});
      chk("rf_wnum", {27'd0, rf_wnum}, m_valid ? {27'd0, m_wnum} : 32'd0);
      chk("rf_wdata", rf_wdata, m_valid ? exp_data() : 32'd0);
      chk("fwd_valid", {31'd0, wb_fwd_valid}, (exp_we() != 4'd0) ? 32'd1 : 32'd0);
      chk("fwd_wnum", {27'd0, wb_fwd_wnum}, m_valid ? {27'd0, m_wnum} : 32'd0);
      chk("fwd_data", wb_fwd_data, m_valid ? exp_data() : 32'd0);
      chk("retire_cnt", retire_cnt, m_cnt);
`ifdef WB_DEBUG_TRACE_EN
      chk("dbg_pc", debug_wb_pc, m_valid ? m_pc : 32'd0);
      chk("dbg_wen", {28'd0, debug_wb_rf_wen}, {28'd0, exp_we()});
      chk("dbg_wnum", {27'd0, debug_wb_rf_wnum}, m_valid ? {27'd0, m_wnum} : 32'd0);
      chk("dbg_wdata", debug_wb_rf_wdata, m_valid ? exp_data() : 32'd0);
`endif
    end
  end

  task automatic set_mem(input logic v, input logic [31:0] pc, input logic [2:0] sel,
                         input logic [31:0] wbd, input logic [4:0] lu, input logic [1:0] a,
                         input logic [2:0] wt, input logic [3:0] llr, input logic [4:0] wn);
    mif.mem_valid_in = v; mif.mem_pc_in = pc; mif.mem_sel_wbdata_in = sel;
    mif.mem_wbdata_in = wbd; mif.mem_lubhw_con_in = lu; mif.mem_adrl_in = a;
    mif.mem_write_type_in = wt; mif.mem_llr_we_in = llr; mif.mem_wnum_in = wn;
  endtask

  task automatic set_random(input logic v);
    logic [31:0] r, pc, wbd;
    logic [4:0]  lu, wn;
    int k;
    r = $urandom; pc = $urandom; wbd = $urandom;
    k = $urandom_range(0, 5);
    lu = (k == 5) ? 5'd0 : (5'd1 << k);
    wn = ($urandom_range(0, 3) == 0) ? 5'd0 : r[4:0];
    set_mem(v, pc, r[7:5], wbd, lu, r[9:8], r[12:10], r[16:13], wn);
  endtask

  // Entered and left at posedge+1; issues one instruction then a bubble.
  task automatic directed(input string nm, input logic [2:0] sel, input logic [31:0] wbd,
                          input logic [4:0] lu, input logic [1:0] a, input logic [2:0] wt,
                          input logic [3:0] llr, input logic [4:0] wn, input logic [31:0] rdata,
                          input logic [3:0] ewe, input logic [31:0] ewd);
    logic [31:0] pc;
    pc = $urandom;
    set_mem(1'b1, pc, sel, wbd, lu, a, wt, llr, wn);
    @(posedge clk); #1;
    rd = rdata;
    set_random(1'b0);
    @(negedge clk);
    chk({nm, "_we"}, {28'd0, rf_we}, {28'd0, ewe});
    chk({nm, "_wdata"}, rf_wdata, ewd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    rd  = 32'd0;
    set_mem(1'b0, 32'd0, 3'd0, 32'd0, 5'd0, 2'd0, 3'd0, 4'd0, 5'd0);
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_retire", retire_cnt, 32'd0);
    chk("reset_we", {28'd0, rf_we}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    directed("normal", 3'b100, 32'h1234_5678, 5'b00000, 2'd0, 3'b001, 4'd0, 5'd5,
             32'hDEAD_BEEF, 4'b1111, 32'h1234_5678);
    chk("retire_first", retire_cnt, 32'd1);
    chk("bubble_we", {28'd0, rf_we}, 32'd0);
    directed("lb_a2",  3'b000, 32'd0, 5'b00010, 2'd2, 3'b001, 4'd0, 5'd3, 32'h80FF_7F01, 4'hF, 32'hFFFF_FFFF);
    directed("lbu_a2", 3'b000, 32'd0, 5'b00100, 2'd2, 3'b001, 4'd0, 5'd3, 32'h80FF_7F01, 4'hF, 32'h0000_00FF);
    directed("lb_a1",  3'b000, 32'd0, 5'b00010, 2'd1, 3'b001, 4'd0, 5'd3, 32'h80FF_7F01, 4'hF, 32'h0000_007F);
    directed("lh_a2",  3'b000, 32'd0, 5'b01000, 2'd2, 3'b001, 4'd0, 5'd4, 32'h8001_ABCD, 4'hF, 32'hFFFF_8001);
    directed("lhu_a2", 3'b000, 32'd0, 5'b10000, 2'd2, 3'b001, 4'd0, 5'd4, 32'h8001_ABCD, 4'hF, 32'h0000_8001);
    directed("lh_a0",  3'b000, 32'd0, 5'b01000, 2'd0, 3'b001, 4'd0, 5'd4, 32'h8001_ABCD, 4'hF, 32'hFFFF_ABCD);
    directed("lwl",    3'b000, 32'd0, 5'b00000, 2'd1, 3'b010, 4'b1100, 5'd7, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_0000);
    directed("lwr",    3'b000, 32'd0, 5'b00000, 2'd2, 3'b011, 4'b0011, 5'd7, 32'hAABB_CCDD, 4'b0011, 32'h0000_AABB);
    directed("r0",     3'b100, 32'h0BAD_F00D, 5'b00000, 2'd0, 3'b001, 4'd0, 5'd0, 32'd0, 4'd0, 32'h0BAD_F00D);
    chk("retire_directed", retire_cnt, 32'd10);

    // Reset in the middle of a valid WB cycle drops the write at once.
    set_mem(1'b1, 32'h0000_1000, 3'b100, 32'h5555_AAAA, 5'd0, 2'd0, 3'b001, 4'd0, 5'd9);
    @(posedge clk); #1;
    rd = $urandom;
    set_random(1'b0);
    chk("pre_reset_we", {28'd0, rf_we}, 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_we", {28'd0, rf_we}, 32'd0);
    chk("async_retire", retire_cnt, 32'd0);
    chk("async_fwd", {31'd0, wb_fwd_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_mem(1'b1, 32'h0000_2000, 3'b100, 32'h0000_0001, 5'd0, 2'd0, 3'b001, 4'd0, 5'd1);
    @(posedge clk); #1;
    chk("b2b_retire0", retire_cnt, 32'd0);
    set_mem(1'b1, 32'h0000_2004, 3'b100, 32'h0000_0002, 5'd0, 2'd0, 3'b001, 4'd0, 5'd2);
    @(posedge clk); #1;
    chk("b2b_retire1", retire_cnt, 32'd1);
    set_mem(1'b1, 32'h0000_2008, 3'b100, 32'h0000_0003, 5'd0, 2'd0, 3'b001, 4'd0, 5'd3);
    @(posedge clk); #1;
    chk("b2b_retire2", retire_cnt, 32'd2);
    set_random(1'b0);
    @(posedge clk); #1;
    chk("b2b_retire3", retire_cnt, 32'd3);

    repeat (400) begin
      rd = $urandom;
      set_random(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
